// File: rtl/axis_fifo_if.sv
// axis_fifo_if: valid/ready byte-stream bundle for axis_fifo.
//   Write side : idata, ivalid (to FIFO), iready (from FIFO)
//   Read side  : odata, ovalid (from FIFO), oready (to FIFO)
//   Status     : count (stored entries, 0..2**ADDR_WIDTH), almost_full (registered)
// Modports:
//   slave  - the FIFO itself
//   master - the surrounding producer/consumer environment
interface axis_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] idata;
  logic                  ivalid;
  logic                  iready;
  logic [DATA_WIDTH-1:0] odata;
  logic                  ovalid;
  logic                  oready;
  logic [ADDR_WIDTH:0]   count;
  logic                  almost_full;

  modport slave (
    input  idata,
    input  ivalid,
    input  oready,
    output iready,
    output odata,
    output ovalid,
    output count,
    output almost_full
  );

  modport master (
    output idata,
    output ivalid,
    output oready,
    input  iready,
    input  odata,
    input  ovalid,
    input  count,
    input  almost_full
  );

endinterface

// File: rtl/axis_fifo.sv
// axis_fifo: synchronous byte-stream FIFO on a valid/ready handshake.
// Absorbs bursts when the downstream consumer stalls and raises almost_full early
// so the upstream receiver can apply flow control before data is lost.
// Ports:
//   clock - single clock, all state on posedge
//   reset - asynchronous, active-high; clears pointers, count and almost_full
//   bus   - axis_fifo_if.slave: idata/ivalid/iready in, odata/ovalid/oready out,
//           count and almost_full status
// iready and ovalid are decoded from the registered count only, so neither depends
// combinationally on ivalid or oready. odata is an asynchronous read of the head
// entry (distributed RAM style) and is meaningless while ovalid is low.
module axis_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned ALMOST_FULL = 12
) (
  input logic        clock,
  input logic        reset,
  axis_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CountFull = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CountAf   = (ADDR_WIDTH + 1)'(ALMOST_FULL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  almost_full_q, almost_full_d;

  logic not_full;
  logic not_empty;
  logic push;
  logic pop;

  // Handshake decode
  always_comb begin
    not_full  = (count_q != CountFull);
    not_empty = (count_q != '0);
    push      = bus.ivalid && not_full;
    pop       = bus.oready && not_empty;
  end

  // Next-state: pointers wrap naturally modulo DEPTH
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Built from the current registered count, so it trails count by one cycle.
    almost_full_d = (count_q >= CountAf);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Storage is deliberately not reset; reset only discards contents via the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr_q] <= bus.idata;
    end
  end

  always_comb begin
    bus.iready      = not_full;
    bus.ovalid      = not_empty;
    bus.odata       = mem[rptr_q];
    bus.count       = count_q;
    bus.almost_full = almost_full_q;
  end

endmodule
